nibble_word_collector: RTL and testbench

- Sits directly downstream of the HLS wrapper's debug output (4-bit data_out, data_valid, probe_out).
- Packs the nibble stream into 32-bit words and buffers them in a small FWFT FIFO with valid/ready output.
- Keeps a word count, sticky overflow and done flags, and optionally a running checksum, for on-board readback and simulation scoreboarding.

---
 rtl/nwc_pkg.sv | 22 ++
 rtl/nwc_fifo.sv | 47 ++++
 rtl/nibble_word_collector.sv | 138 +++++++++++++
 tb/tb_nibble_word_collector.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nwc_pkg.sv
// Shared definitions for the nibble word collector: FSM state encoding and width helpers.
package nwc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } nwc_state_t;

    localparam int NWC_NIB_W = 4;

    function automatic int nwc_word_w(input int nibbles);
        return NWC_NIB_W * nibbles;
    endfunction

    // The checksum accumulates whole words, so it shares the word width.
    function automatic int nwc_csum_w(input int nibbles);
        return nwc_word_w(nibbles);
    endfunction

endpackage

// File: rtl/nwc_fifo.sv
// FWFT synchronous FIFO, head visible the cycle after the first push; caller must not push when
// full without a same-cycle pop, nor pop when empty. Head reads as zero while empty.
module nwc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_i);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

    // The extra pointer bit distinguishes a full wrap from empty.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/nibble_word_collector.sv
// Packs a nibble stream into words (first nibble = LSB) into an FWFT FIFO; 1-cycle push-to-valid,
// no input backpressure (words dropped with sticky overflow when full). NWC_CHECKSUM_EN adds a running sum.
module nibble_word_collector
    import nwc_pkg::*;
#(
    parameter int  NIBBLES_PER_WORD = 8,
    parameter int  FIFO_DEPTH       = 4,
    parameter int  CNT_W            = 16,
    localparam int WORD_W           = nwc_word_w(NIBBLES_PER_WORD),
    localparam int CSUM_W           = nwc_csum_w(NIBBLES_PER_WORD)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [3:0]        nib_in,
    input  logic              nib_valid,
    input  logic              probe_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  word_count,
    output logic              overflow,
    output logic              done,
    output logic [CSUM_W-1:0] checksum
);

    localparam int IDX_W = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_WORD - 1);

    nwc_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] pack_q, pack_d, word_nxt, push_dat;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              probe_q, ovf_q, ovf_d, done_q, done_d;
    logic              probe_edge, nib_accept, word_done, flush_push, set_done;
    logic              push_req, push_ok, pop, fifo_full, fifo_empty;

    assign probe_edge = probe_in && !probe_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (probe_edge)     state_d = nib_valid ? FLUSH : DONE;
                else if (nib_valid) state_d = COLLECT;
            end
            COLLECT: if (probe_edge) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = DONE;
        endcase
    end

    always_comb begin
        nib_accept = nib_valid && ((state_q == IDLE) || (state_q == COLLECT));
        flush_push = (state_q == FLUSH) && (idx_q != '0);
        set_done   = (state_q == FLUSH) || ((state_q == IDLE) && probe_edge && !nib_valid);
    end

    always_comb begin
        word_nxt = pack_q;
        word_nxt[NWC_NIB_W*int'(idx_q) +: NWC_NIB_W] = nib_in;
        word_done = nib_accept && (idx_q == LAST_IDX);
        push_req  = word_done || flush_push;
        push_dat  = word_done ? word_nxt : pack_q;
        pop       = !fifo_empty && word_ready;
        // A same-cycle pop frees the slot a push into a full FIFO needs.
        push_ok   = push_req && (!fifo_full || pop);

        pack_d = pack_q;
        idx_d  = idx_q;
        if (word_done || (state_q == FLUSH)) begin
            pack_d = '0;
            idx_d  = '0;
        end else if (nib_accept) begin
            pack_d = word_nxt;
            idx_d  = idx_q + IDX_W'(1);
        end

        count_d = (push_ok && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
        ovf_d   = ovf_q || (push_req && !push_ok);
        done_d  = done_q || set_done;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            idx_q   <= '0;
            pack_q  <= '0;
            probe_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            pack_q  <= pack_d;
            probe_q <= probe_in;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    nwc_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (ap_clk),
        .rst_i      (ap_rst),
        .push_i     (push_ok),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (word_out),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign word_valid = !fifo_empty;
    assign word_count = count_q;
    assign overflow   = ovf_q;
    assign done       = done_q;

`ifdef NWC_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)       csum_q <= '0;
        else if (push_ok) csum_q <= csum_q + push_dat;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_nibble_word_collector.sv
// Randomized self-checking bench for nibble_word_collector against a nibble-list packing model.
module tb_nibble_word_collector;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  nib_in;
    logic        nib_valid;
    logic        probe_in;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [15:0] word_count;
    logic        overflow;
    logic        done;
    logic [31:0] checksum;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    bit          seen_valid;

    always #5 ap_clk = ~ap_clk;

    nibble_word_collector dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid),
        .probe_in   (probe_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_count (word_count),
        .overflow   (overflow),
        .done       (done),
        .checksum   (checksum)
    );

    // Consumer side: record every word that is handed over on the next rising edge.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (word_valid) seen_valid = 1'b1;
            if (word_valid && word_ready) got.push_back(word_out);
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle(input int n);
        nib_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [3:0] n);
        nib_in    = n;
        nib_valid = 1'b1;
        step();
        nib_valid = 1'b0;
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        nib_valid = 1'b0;
        probe_in  = 1'b0;
        nib_in    = 4'h0;
        step();
        step();
        ap_rst = 1'b0;
        got.delete();
        seen_valid = 1'b0;
    endtask

    // Word j is the weighted sum of nibbles 8j..8j+7; a short tail is implicitly zero-padded.
    task automatic build_expected(input logic [3:0] nibs[$]);
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < nibs.size(); i += 8) begin
            w = '0;
            for (int k = 0; k < 8; k++)
                if (i + k < nibs.size()) w += 32'(nibs[i+k]) << (4 * k);
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [31:0] csum_of(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n && i < exp_q.size(); i++) s += exp_q[i];
`ifndef NWC_CHECKSUM_EN
        s = '0;
`endif
        return s;
    endfunction

    task automatic test_reset();
        ap_rst = 1'b1; nib_valid = 1'b0; probe_in = 1'b0; nib_in = 4'h0; word_ready = 1'b1;
        step(); step();
        @(negedge ap_clk);
        total++; if (word_out !== 32'h0) begin bad++; $display("FAIL reset_word_out got=%h exp=0", word_out); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_word_valid got=%b exp=0", word_valid); end
        total++; if (word_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", word_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (checksum !== 32'h0) begin bad++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
        ap_rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] nibs[$];
        do_reset();
        word_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            nibs.push_back(4'(i));
            send(4'(i));
        end
        idle(6);
        build_expected(nibs);
        total++; if (got.size() != 2) begin bad++; $display("FAIL basic_nwords got=%0d exp=2", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++; $display("FAIL basic_word%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            end
        end
        total++; if (word_count !== 16'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", word_count); end
        total++; if (checksum !== csum_of(2)) begin bad++; $display("FAIL basic_checksum got=%h exp=%h", checksum, csum_of(2)); end
        total++; if (done !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b exp=00", done, overflow); end
    endtask

    task automatic test_partial_flush();
        logic [3:0] nibs[$] = '{4'hA, 4'hB, 4'hC};
        do_reset();
        word_ready = 1'b1;
        foreach (nibs[i]) send(nibs[i]);
        build_expected(nibs);
        probe_in = 1'b1;
        step();
        @(negedge ap_clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL partial_done_in_flush got=%b exp=0", done); end
        step();
        @(negedge ap_clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL partial_done_after got=%b exp=1", done); end
        total++; if (word_valid !== 1'b1 || word_out !== exp_q[0]) begin
            bad++; $display("FAIL partial_head got=%b/%h exp=1/%h", word_valid, word_out, exp_q[0]);
        end
        idle(4);
        total++; if (got.size() != 1) begin bad++; $display("FAIL partial_nwords got=%0d exp=1", got.size()); end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL partial_count got=%0d exp=1", word_count); end
        total++; if (checksum !== csum_of(1)) begin bad++; $display("FAIL partial_checksum got=%h exp=%h", checksum, csum_of(1)); end
    endtask

    task automatic test_overflow();
        logic [3:0] nibs[$];
        logic [3:0] n;
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n = 4'($urandom_range(0, 15));
            nibs.push_back(n);
            send(n);
        end
        idle(3);
        build_expected(nibs);
        total++; if (word_count !== 16'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", word_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (word_valid !== 1'b1 || word_out !== exp_q[0]) begin
            bad++; $display("FAIL ovf_head got=%b/%h exp=1/%h", word_valid, word_out, exp_q[0]);
        end
        idle(3);
        total++; if (word_out !== exp_q[0]) begin bad++; $display("FAIL ovf_head_stable got=%h exp=%h", word_out, exp_q[0]); end
        word_ready = 1'b1;
        idle(10);
        total++; if (got.size() != 4) begin bad++; $display("FAIL ovf_ndrained got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            end
        end
        total++; if (overflow !== 1'b1 || word_valid !== 1'b0) begin
            bad++; $display("FAIL ovf_after_drain got=%b/%b exp=1/0", overflow, word_valid);
        end
    endtask

    task automatic test_push_pop_full();
        logic [3:0] nibs[$];
        logic [3:0] n;
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n = 4'($urandom_range(0, 15));
            nibs.push_back(n);
            if (i == 39) word_ready = 1'b1;
            send(n);
        end
        idle(10);
        build_expected(nibs);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
        total++; if (word_count !== 16'd5) begin bad++; $display("FAIL pp_count got=%0d exp=5", word_count); end
        total++; if (got.size() != 5) begin bad++; $display("FAIL pp_nwords got=%0d exp=5", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++; $display("FAIL pp_word%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] nibs[$];
        logic [3:0] n;
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 4'($urandom_range(0, 15));
            nibs.push_back(n);
            if (i == 7) probe_in = 1'b1;
            send(n);
        end
        idle(6);
        build_expected(nibs);
        total++; if (got.size() != 1) begin bad++; $display("FAIL simul_nwords got=%0d exp=1", got.size()); end
        total++; if (got.size() < 1 || got[0] !== exp_q[0]) begin
            bad++; $display("FAIL simul_word got=%h exp=%h", (got.size() > 0) ? got[0] : 32'hx, exp_q[0]);
        end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL simul_count got=%0d exp=1", word_count); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL simul_done got=%b exp=1", done); end
        total++; if (checksum !== csum_of(1)) begin bad++; $display("FAIL simul_checksum got=%h exp=%h", checksum, csum_of(1)); end
    endtask

    task automatic test_reset_midword();
        logic [3:0] nibs[$];
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 13; i++) send(4'($urandom_range(0, 15)));
        ap_rst = 1'b1;
        step();
        @(negedge ap_clk);
        total++; if (word_valid !== 1'b0 || word_out !== 32'h0) begin
            bad++; $display("FAIL rst_mid_fifo got=%b/%h exp=0/0", word_valid, word_out);
        end
        total++; if (word_count !== 16'h0 || overflow !== 1'b0 || done !== 1'b0 || checksum !== 32'h0) begin
            bad++; $display("FAIL rst_mid_flags got=%0d/%b/%b/%h exp=0/0/0/0", word_count, overflow, done, checksum);
        end
        ap_rst = 1'b0;
        got.delete();
        word_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            nibs.push_back(4'(i));
            send(4'(i));
        end
        idle(5);
        build_expected(nibs);
        total++; if (got.size() != 1 || got[0] !== exp_q[0]) begin
            bad++; $display("FAIL rst_mid_word got=%0d/%h exp=1/%h", got.size(), (got.size() > 0) ? got[0] : 32'hx, exp_q[0]);
        end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL rst_mid_count got=%0d exp=1", word_count); end
    endtask

    task automatic test_empty_run();
        do_reset();
        word_ready = 1'b1;
        probe_in = 1'b1;
        idle(6);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL empty_done got=%b exp=1", done); end
        total++; if (seen_valid !== 1'b0) begin bad++; $display("FAIL empty_valid_seen got=%b exp=0", seen_valid); end
        total++; if (word_count !== 16'h0 || checksum !== 32'h0) begin
            bad++; $display("FAIL empty_count_csum got=%0d/%h exp=0/0", word_count, checksum);
        end
    endtask

    task automatic test_random();
        logic [3:0] nibs[$];
        logic [3:0] n;
        int         cnt;
        bit         coincide;
        for (int it = 0; it < 8; it++) begin
            nibs.delete();
            do_reset();
            word_ready = 1'b1;
            cnt      = $urandom_range(0, 35);
            coincide = ($urandom_range(0, 1) == 1) && (cnt > 0);
            for (int i = 0; i < cnt; i++) begin
                idle($urandom_range(0, 2));
                n = 4'($urandom_range(0, 15));
                nibs.push_back(n);
                if (coincide && i == cnt - 1) probe_in = 1'b1;
                send(n);
            end
            if (!coincide) begin
                idle($urandom_range(0, 2));
                probe_in = 1'b1;
            end
            idle(10);
            build_expected(nibs);
            total++; if (got.size() != exp_q.size()) begin
                bad++; $display("FAIL rand%0d_nwords got=%0d exp=%0d", it, got.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (i >= got.size() || got[i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand%0d_word%0d got=%h exp=%h", it, i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
                end
            end
            total++; if (word_count !== 16'(exp_q.size())) begin
                bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, word_count, exp_q.size());
            end
            total++; if (checksum !== csum_of(exp_q.size())) begin
                bad++; $display("FAIL rand%0d_checksum got=%h exp=%h", it, checksum, csum_of(exp_q.size()));
            end
            total++; if (done !== 1'b1 || overflow !== 1'b0) begin
                bad++; $display("FAIL rand%0d_flags got=%b%b exp=10", it, done, overflow);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_flush();
        test_overflow();
        test_push_pop_full();
        test_simultaneous();
        test_reset_midword();
        test_empty_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
